vdc_htiming_gen: RTL

// Parametrised horizontal timing generator for the VDC core. Successor to the fixed 8-bit horizontal

---
 rtl/vdc_pkg.sv | 17 +
 rtl/vdc_lfsr16.sv | 24 ++
 rtl/vdc_htiming_gen.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/vdc_pkg.sv
// Shared constants for the VDC horizontal timing path.
// Covers the visible-window start, enable-point adjust threshold, LFSR seed/taps and hviscol end offsets.
package vdc_pkg;

    localparam int unsigned VIS_START_DEF = 8;
    localparam int unsigned DE_ADJ_LO     = 7;

    // hviscol end-column offsets relative to reg_hd
    localparam int unsigned HV_END_AI     = 7;
    localparam int unsigned HV_END        = 8;
    localparam int unsigned HV_END_DBL    = 9;

    // x^16 + x^14 + x^13 + x^11, right-shifting Fibonacci form
    localparam logic [15:0] LFSR_SEED     = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS     = 16'h002D;

endpackage

// File: rtl/vdc_lfsr16.sv
// 16-bit Fibonacci LFSR used as the pseudo-random display-enable source.
// Advances by one state on each cycle where step is high.
module vdc_lfsr16
    import vdc_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        step,
    output logic [15:0] q
);

    logic [15:0] r_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= LFSR_SEED;
        end else if (step) begin
            r_q <= {^(r_q & LFSR_TAPS), r_q[15:1]};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/vdc_htiming_gen.sv
// Horizontal timing generator: pixel/column counters, display enable, hsync and hblank.
// State advances only on cycles with enable high.
module vdc_htiming_gen
    import vdc_pkg::*;
#(
    parameter int unsigned COLW      = 8,
    parameter int unsigned PIXW      = 4,
    parameter int unsigned SYNCW     = 4,
    parameter int unsigned VIS_START = VIS_START_DEF,
    parameter int unsigned RAND_SRC  = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [7:0]       db_in,
    input  logic [COLW-1:0]  reg_ht,
    input  logic [COLW-1:0]  reg_hd,
    input  logic [COLW-1:0]  reg_hp,
    input  logic [SYNCW-1:0] reg_hw,
    input  logic [PIXW-1:0]  reg_cth,
    input  logic             reg_atr,
    input  logic             reg_dbl,
    input  logic [COLW-1:0]  reg_ai,
    input  logic [COLW-1:0]  reg_deb,
    input  logic [COLW-1:0]  reg_dee,
    output logic             newCol,
    output logic             endCol,
    output logic             newLine,
    output logic [COLW-1:0]  col,
    output logic [PIXW-1:0]  pixel,
    output logic             hVisible,
    output logic             hdispen,
    output logic             hsync,
    output logic             hblank
);

    logic [COLW-1:0]  r_col;
    logic [PIXW-1:0]  r_pixel;
    logic             r_new_col;
    logic             r_end_col;
    logic             r_new_line;
    logic             r_hdispen;
    logic             r_hviscol;
    logic [SYNCW-1:0] r_sync_cnt;

    logic [COLW-1:0]  w_de_lim;
    logic [COLW-1:0]  w_deb_adj;
    logic [COLW-1:0]  w_dee_adj;
    logic [COLW-1:0]  w_hv_end;
    logic             w_wrap;
    logic             w_hv_clr;
    logic             w_rand;
    logic [15:0]      w_lfsr_q;
    logic             w_unused;

    // Enable points shift by one extra column inside the active window
    always_comb begin
        w_de_lim  = reg_hd + COLW'(DE_ADJ_LO);
        w_deb_adj = reg_deb + COLW'(1);
        w_dee_adj = reg_dee + COLW'(1);
        if (reg_deb >= COLW'(DE_ADJ_LO) && reg_deb < w_de_lim) begin
            w_deb_adj = reg_deb + COLW'(2);
        end
        if (reg_dee >= COLW'(DE_ADJ_LO) && reg_dee < w_de_lim) begin
            w_dee_adj = reg_dee + COLW'(2);
        end
    end

    always_comb begin
        w_wrap   = (r_col == reg_ht);
        w_hv_end = reg_hd + COLW'(((reg_ai != '0) && !reg_atr) ? HV_END_AI : HV_END);
        w_hv_clr = (reg_dbl && r_new_col && (r_col == reg_hd + COLW'(HV_END_DBL))) ||
                   (!reg_dbl && r_end_col && (r_col == w_hv_end));
    end

    generate
        if (RAND_SRC != 0) begin : g_lfsr
            vdc_lfsr16 u_lfsr (
                .clk     (clk),
                .reset_n (reset_n),
                .step    (enable & r_new_line),
                .q       (w_lfsr_q)
            );
            assign w_rand = w_lfsr_q[0];
        end else begin : g_parity
            assign w_lfsr_q = '0;
            assign w_rand   = db_in[0] ^ db_in[1] ^ db_in[5] ^ db_in[7];
        end
    endgenerate

    assign w_unused = &{1'b0, db_in, w_lfsr_q[15:1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_col      <= '0;
            r_pixel    <= '0;
            r_new_col  <= 1'b0;
            r_end_col  <= 1'b1;
            r_new_line <= 1'b0;
            r_hdispen  <= 1'b0;
            r_hviscol  <= 1'b0;
            r_sync_cnt <= '0;
        end else if (enable) begin
            r_new_col  <= r_end_col;
            r_end_col  <= (r_pixel == reg_cth - PIXW'(1));
            r_new_line <= r_end_col && w_wrap;
            r_pixel    <= r_end_col ? PIXW'(reg_dbl) : r_pixel + PIXW'(1);

            if (r_end_col) begin
                r_col <= w_wrap ? '0 : r_col + COLW'(1);

                // Later assignments take priority
                if (w_wrap && (w_deb_adj >= reg_ht)) begin
                    r_hdispen <= 1'b1;
                end
                if (w_deb_adj != w_dee_adj) begin
                    if (r_col == w_deb_adj) r_hdispen <= 1'b1;
                    if (r_col == w_dee_adj) r_hdispen <= 1'b0;
                end else if (r_col == w_deb_adj) begin
                    r_hdispen <= w_rand;
                end

                if (r_col == reg_hp) begin
                    r_sync_cnt <= reg_hw >> reg_dbl;
                end else if (r_sync_cnt != '0) begin
                    r_sync_cnt <= r_sync_cnt - SYNCW'(1);
                end
            end

            if (w_hv_clr) begin
                r_hviscol <= 1'b0;
            end else if (r_end_col && (r_col == COLW'(VIS_START))) begin
                r_hviscol <= 1'b1;
            end
        end
    end

    assign col      = r_col;
    assign pixel    = r_pixel;
    assign newCol   = r_new_col;
    assign endCol   = r_end_col;
    assign newLine  = r_new_line;
    assign hdispen  = r_hdispen;
    assign hVisible = r_hviscol & r_hdispen;
    assign hsync    = |r_sync_cnt;
    assign hblank   = hsync | ~r_hviscol;

endmodule
